// File: rtl/uart_vec_loader.sv
// UART 8N1 receiver that packs 16 received bytes into one 128-bit
// vector word and writes it to the memory stage user port.
module uart_vec_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              clr_addr,
  output logic              user_data_EN,
  output logic [127:0]      user_data_in,
  output logic [ADDR_W-1:0] address_b,
  output logic [3:0]        byte_count,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shf_q, shf_d;
  logic        rx_m_q, rx_s_q, rx_p_q;

  logic              en_q;
  logic [127:0]      word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        cnt_q;
  logic              err_q;

  logic       fall;
  logic       tmr_done;
  logic       byte_ok;
  logic       byte_bad;
  logic [3:0] lane;

  assign fall     = rx_p_q & ~rx_s_q;
  assign tmr_done = (state_q == START) ? (tmr_q == HALF_LAST)
                                       : (tmr_q == BIT_LAST);
  // An in-flight byte lands in lane 0 when clr_addr hits its stop sample
  assign lane     = clr_addr ? 4'd0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      rx_p_q  <= rx_s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 16'd1;
    bit_d   = bit_q;
    shf_d   = shf_q;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (tmr_done) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr_done) begin
          tmr_d = '0;
          shf_d = {rx_s_q, shf_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tmr_done) begin
          tmr_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy  = (state_q != IDLE);
    byte_ok  = (state_q == STOP) & tmr_done & rx_s_q;
    byte_bad = (state_q == STOP) & tmr_done & ~rx_s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      word_q <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      en_q <= byte_ok & (lane == 4'd15);
      if (byte_ok) begin
        word_q[{lane, 3'b000} +: 8] <= shf_q;
        cnt_q <= lane + 4'd1;
      end else if (clr_addr) begin
        cnt_q <= '0;
      end
      if (clr_addr) addr_q <= '0;
      else if (en_q) addr_q <= addr_q + 1'b1;
      if (byte_bad) err_q <= 1'b1;
      else if (clr_addr) err_q <= 1'b0;
    end
  end

  assign user_data_EN = en_q;
  assign user_data_in = word_q;
  assign address_b    = addr_q;
  assign byte_count   = cnt_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_uart_vec_loader.sv
// Scoreboard bench for uart_vec_loader: a byte-level model predicts
// every word strobe and the counters after each scenario.
module tb_uart_vec_loader;

  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx;
  logic         clr_addr;
  logic         user_data_EN;
  logic [127:0] user_data_in;
  logic [15:0]  address_b;
  logic [3:0]   byte_count;
  logic         frame_err;
  logic         rx_busy;

  uart_vec_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .clr_addr(clr_addr),
    .user_data_EN(user_data_EN),
    .user_data_in(user_data_in),
    .address_b(address_b),
    .byte_count(byte_count),
    .frame_err(frame_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  a;
    logic [127:0] w;
  } exp_t;

  exp_t         sbq[$];
  int           n_tot = 0;
  int           n_bad = 0;
  logic [127:0] m_word = '0;
  int           m_cnt = 0;
  logic [15:0]  m_addr = '0;
  logic         m_err = 1'b0;
  logic         clr_mode = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_word[8*m_cnt +: 8] = b;
    if (m_cnt == 15) begin
      sbq.push_back('{m_addr, m_word});
      m_cnt  = 0;
      m_addr = clr_mode ? 16'd0 : m_addr + 16'd1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    drive_frame(b, 1'b1);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"}, 128'(byte_count), 128'(m_cnt));
    chk({tag, "_addr"}, 128'(address_b), 128'(m_addr));
    chk({tag, "_err"}, 128'(frame_err), 128'(m_err));
  endtask

  task automatic pulse_clr();
    clr_addr = 1'b1;
    @(negedge clk);
    clr_addr = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    m_err  = 1'b0;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (user_data_EN) begin
        if (sbq.size() == 0) begin
          chk("spurious_strobe", 128'(1), 128'(0));
        end else begin
          e = sbq.pop_front();
          chk("strobe_word", user_data_in, e.w);
          chk("strobe_addr", 128'(address_b), 128'(e.a));
        end
      end
    end
  end

  initial begin : watchdog
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    logic seen;
    rst = 1'b1;
    rx = 1'b1;
    clr_addr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", 128'(user_data_EN), 128'(0));
    chk("rst_word", user_data_in, 128'(0));
    chk("rst_busy", 128'(rx_busy), 128'(0));
    chk_state("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) send(8'(i));
    chk_state("seq");

    pulse_clr();
    for (int i = 0; i < 32; i++) send(8'hA5);
    chk_state("a5");

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("glitch_busy", 128'(rx_busy), 128'(1));
    repeat (8) @(negedge clk);
    chk("glitch_idle", 128'(rx_busy), 128'(0));
    chk_state("glitch");

    for (int i = 0; i < 3; i++) send(8'(8'h30 + i));
    drive_frame(8'h55, 1'b0);
    m_err = 1'b1;
    chk_state("ferr");
    chk("ferr_word", user_data_in, m_word);
    send(8'h3C);
    chk_state("ferr_next");
    chk("ferr_lane", user_data_in, m_word);

    fork
      drive_frame(8'h9E, 1'b1);
      begin
        repeat (10) @(negedge clk);
        clr_addr = 1'b1;
        @(negedge clk);
        clr_addr = 1'b0;
      end
    join
    m_cnt  = 0;
    m_addr = '0;
    m_err  = 1'b0;
    model_byte(8'h9E);
    chk_state("clr_fly");
    chk("clr_lane0", 128'(user_data_in[7:0]), 128'(8'h9E));

    for (int i = 1; i < 15; i++) send(8'(8'h60 + i));
    clr_mode = 1'b1;
    model_byte(8'h7F);
    clr_mode = 1'b0;
    seen = 1'b0;
    fork
      drive_frame(8'h7F, 1'b1);
      begin
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (user_data_EN) seen = 1'b1;
        end
        if (seen) begin
          clr_addr = 1'b1;
          @(negedge clk);
          clr_addr = 1'b0;
        end else begin
          chk("clr_strobe_wait", 128'(0), 128'(1));
        end
      end
    join
    chk_state("clr_strobe");

    force dut.addr_q = 16'hFFFF;
    @(negedge clk);
    release dut.addr_q;
    m_addr = 16'hFFFF;
    @(negedge clk);
    chk("force_addr", 128'(address_b), 128'(16'hFFFF));
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i));
    chk_state("wrap");

    for (int i = 0; i < 5; i++) send(8'(8'hD0 + i));
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    m_err  = 1'b0;
    m_word = '0;
    repeat (2) @(negedge clk);
    chk("rst2_word", user_data_in, 128'(0));
    chk("rst2_busy", 128'(rx_busy), 128'(0));
    chk_state("rst2");
    for (int i = 0; i < 16; i++) send(8'(8'hE0 + i));
    chk_state("rst2_after");

    repeat (4) @(negedge clk);
    chk("sb_empty", 128'(sbq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_vec_loader.md
UART_VEC_LOADER -- requirements
Module: uart_vec_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning width of the word address sent to the memory stage user port.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial line, idle high.
REQ-006 SHALL have port clr_addr  input  1  synchronous clear of word address and byte position.
REQ-007 SHALL have port user_data_EN  output  1  one-cycle memory write strobe.
REQ-008 SHALL have port user_data_in  output  128  assembled 16-byte vector word.
REQ-009 SHALL have port address_b  output  ADDR_W  word address for the current write.
REQ-010 SHALL have port byte_count  output  4  bytes already collected into the current word.
REQ-011 SHALL have port frame_err  output  1  sticky framing-error flag.
REQ-012 SHALL have port rx_busy  output  1  high whenever the receive FSM is not IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized signal rx_s; rx_s resets to 1.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: on rx_s 1->0 transition, go to START and clear the bit timer; rx held low with no falling edge SHALL NOT start a frame.
REQ-016 START: after CLKS_PER_BIT/2 (integer division) cycles, sample rx_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no error).
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first; then go to STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> byte valid; 0 -> byte discarded, frame_err set; both cases return to IDLE.
REQ-019 A valid byte with byte_count=k SHALL be written to user_data_in[8k+7:8k], then byte_count increments.
REQ-020 When the valid byte has k=15, user_data_en SHALL assert for exactly one cycle, the cycle after the stop sample, with the complete word on user_data_in and the pre-increment address on address_b.
REQ-021 byte_count SHALL wrap 15->0 on that strobe; address_b SHALL increment the cycle after the strobe and wrap from all-ones to 0.
REQ-022 user_data_in SHALL hold its last value between strobes; partial bytes of the next word SHALL overwrite lanes in place.
REQ-023 A framing error SHALL leave byte_count, address_b and user_data_in unchanged.
REQ-024 frame_err SHALL clear only on rst or clr_addr.
REQ-025 clr_addr SHALL zero address_b and byte_count and clear frame_err next cycle, without affecting an in-flight frame; that frame's byte lands in lane 0.
REQ-026 If clr_addr coincides with the strobe cycle, the strobe SHALL still occur with the old address, and address_b SHALL become 0, not old+1.
REQ-027 The bit timer SHALL be at least 16 bits wide; no other arithmetic overflow is permitted.

Reset
REQ-028 On rst SHALL force: FSM IDLE, timers 0, user_data_EN 0, user_data_in 0, address_b 0, byte_count 0, frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-029 rst mid-frame SHALL abort the frame with no strobe, and reception SHALL resume from the next falling edge after rst deasserts.

Verification (CLKS_PER_BIT=4)
REQ-030 Send bytes 0x00..0x0F, 8N1 -> one strobe, user_data_in=0x0F0E..0100, address_b=0 during the strobe, 1 after; byte_count=0.
REQ-031 Send 32 bytes of 0xA5 -> two strobes at addresses 0 and 1, each with word 0xA5 repeated 16 times.
REQ-032 Pull rx low for 1 cycle -> FSM returns to IDLE, no byte, frame_err=0.
REQ-033 Send 0x55 with stop bit 0 -> frame_err=1, byte_count unchanged; next good byte lands in the same lane.
REQ-034 Preload address_b=0xFFFF via 65535 words, or force it in the bench, then send 16 bytes -> strobe at 0xFFFF, then address_b=0x0000.
REQ-035 Assert rst after 5 bytes, then send 16 bytes -> single strobe at address 0 containing only the new 16 bytes.
